// File: rtl/emergency_detector.sv
// Multi-lane siren detector: per-channel run-length debounce plus a fixed-priority
// IDLE/SERVE arbiter. Define EMERG_TIMEOUT_EN to add a service hold timeout.
module emergency_detector #(
  parameter  int NUM_CH      = 4,
  parameter  int THRESH      = 3,
  parameter  int HOLD_CYCLES = 16,
  localparam int CH_W        = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] sound_in,
  input  logic              ack,
  output logic [NUM_CH-1:0] detect_pulse,
  output logic              emergency_valid,
  output logic [CH_W-1:0]   emergency_ch
);

  localparam int CNT_W = $clog2(THRESH + 1);
  localparam logic [CNT_W-1:0] C_SAT  = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(THRESH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SERVE = 1'b1
  } state_t;

  if (NUM_CH < 2 || NUM_CH > 16) begin : g_bad_num_ch
    $error("emergency_detector: NUM_CH out of range 2..16");
  end
  if (THRESH < 1 || THRESH > 255) begin : g_bad_thresh
    $error("emergency_detector: THRESH out of range 1..255");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 65535) begin : g_bad_hold
    $error("emergency_detector: HOLD_CYCLES out of range 1..65535");
  end

  state_t              r_state;
  logic [NUM_CH-1:0]   r_pending;
  logic [NUM_CH-1:0]   w_det;
  logic [NUM_CH-1:0]   w_grant_mask;
  logic [CH_W-1:0]     w_grant_idx;
  logic                w_take;
  logic                w_leave;

  // A detection fires only on the THRESH-1 -> THRESH step, so a saturated
  // counter cannot re-trigger until a low sample clears it.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;

    assign w_det[gi] = sound_in[gi] && (r_cnt == C_LAST);

    always_ff @(posedge clk) begin
      if (!reset) begin
        r_cnt <= '0;
      end else if (!sound_in[gi]) begin
        r_cnt <= '0;
      end else if (r_cnt != C_SAT) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      detect_pulse <= '0;
    end else begin
      detect_pulse <= w_det;
    end
  end

  // Descending scan so the lowest pending index is the final assignment.
  always_comb begin
    w_grant_idx  = '0;
    w_grant_mask = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_grant_idx  = CH_W'(i);
        w_grant_mask = NUM_CH'(1) << i;
      end
    end
  end

  assign w_take = (r_state == S_IDLE) && (|r_pending);

`ifdef EMERG_TIMEOUT_EN
  localparam int TMR_W = ($clog2(HOLD_CYCLES) > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(HOLD_CYCLES - 1);

  logic [TMR_W-1:0] r_timer;

  assign w_leave = ack || (r_timer == C_TMR_LAST);
`else
  assign w_leave = ack;
`endif

  // New detections are OR'd in after the grant clear, so a same-edge
  // re-detection of the channel being granted stays pending.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_pending       <= '0;
      emergency_valid <= 1'b0;
      emergency_ch    <= '0;
`ifdef EMERG_TIMEOUT_EN
      r_timer         <= '0;
`endif
    end else begin
      r_pending <= (r_pending & ~(w_take ? w_grant_mask : '0)) | w_det;
      case (r_state)
        S_IDLE: begin
          if (|r_pending) begin
            r_state         <= S_SERVE;
            emergency_valid <= 1'b1;
            emergency_ch    <= w_grant_idx;
`ifdef EMERG_TIMEOUT_EN
            r_timer         <= '0;
`endif
          end
        end
        S_SERVE: begin
          if (w_leave) begin
            r_state         <= S_IDLE;
            emergency_valid <= 1'b0;
          end
`ifdef EMERG_TIMEOUT_EN
          else begin
            r_timer <= r_timer + 1'b1;
          end
`endif
        end
        default: begin
          r_state         <= S_IDLE;
          emergency_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_emergency_detector.sv
// Self-checking bench for emergency_detector: directed scenarios then random
// traffic, compared every cycle against a behavioural reference model.
module tb_emergency_detector;

  localparam int NUM_CH      = 4;
  localparam int THRESH      = 3;
  localparam int HOLD_CYCLES = 16;
`ifdef EMERG_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] sound_in;
  logic              ack;
  logic [NUM_CH-1:0] detect_pulse;
  logic              emergency_valid;
  logic [1:0]        emergency_ch;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int              m_run [NUM_CH];
  bit [NUM_CH-1:0] m_pend;
  bit [NUM_CH-1:0] m_pulse;
  bit              m_valid;
  int              m_ch;
  int              m_timer;

  emergency_detector #(
    .NUM_CH      (NUM_CH),
    .THRESH      (THRESH),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .sound_in        (sound_in),
    .ack             (ack),
    .detect_pulse    (detect_pulse),
    .emergency_valid (emergency_valid),
    .emergency_ch    (emergency_ch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge of the specification's rules, applied to the model.
  task automatic model_edge(input logic [NUM_CH-1:0] s, input logic a, input logic r);
    bit [NUM_CH-1:0] det;
    int              k;
    bit              leave;
    if (!r) begin
      for (int i = 0; i < NUM_CH; i++) m_run[i] = 0;
      m_pend  = '0;
      m_pulse = '0;
      m_valid = 1'b0;
      m_ch    = 0;
      m_timer = 0;
    end else begin
      det = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        det[i]   = s[i] && (m_run[i] == THRESH - 1);
        m_run[i] = s[i] ? ((m_run[i] < THRESH) ? m_run[i] + 1 : THRESH) : 0;
      end
      if (!m_valid) begin
        k = -1;
        for (int i = NUM_CH - 1; i >= 0; i--) if (m_pend[i]) k = i;
        if (k >= 0) begin
          m_valid   = 1'b1;
          m_ch      = k;
          m_pend[k] = 1'b0;
          m_timer   = 0;
        end
      end else begin
        leave = a || (TO_EN && (m_timer == HOLD_CYCLES - 1));
        if (leave) m_valid = 1'b0;
        else       m_timer = m_timer + 1;
      end
      m_pend  = m_pend | det;
      m_pulse = det;
    end
  endtask

  task automatic step(input logic [NUM_CH-1:0] s, input logic a, input logic r);
    sound_in = s;
    ack      = a;
    reset    = r;
    @(posedge clk);
    model_edge(s, a, r);
    @(negedge clk);
    chk("detect_pulse", detect_pulse, m_pulse);
    chk("emergency_valid", emergency_valid, m_valid);
    if (m_valid) chk("emergency_ch", emergency_ch, m_ch);
  endtask

  initial begin
    int pat [6];
    logic [NUM_CH-1:0] rs;
    logic ra, rr;
    pat = '{1, 1, 0, 1, 1, 1};
    sound_in = '0;
    ack      = 1'b0;
    reset    = 1'b0;

    // Reset state
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    chk("rst_pulse", detect_pulse, 0);
    chk("rst_valid", emergency_valid, 0);
    chk("rst_ch", emergency_ch, 0);

    // Single channel detection and service latency
    for (int i = 0; i < 3; i++) step(4'b0100, 1'b0, 1'b1);
    chk("basic_pulse", detect_pulse, 4'b0100);
    step('0, 1'b0, 1'b1);
    chk("basic_valid", emergency_valid, 1);
    chk("basic_ch", emergency_ch, 2);
    step('0, 1'b0, 1'b1);
    step('0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) step('0, 1'b0, 1'b1);

    // Interrupted run, then saturation with no re-trigger
    for (int i = 0; i < 6; i++) step((pat[i] != 0) ? 4'b0010 : 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(4'b0010, i == 5, 1'b1);
    for (int i = 0; i < 2; i++) step('0, 1'b0, 1'b1);

    // Simultaneous detections served in ascending order
    for (int i = 0; i < 3; i++) step(4'b1010, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step('0, 1'b0, 1'b1);
    step('0, 1'b1, 1'b1);
    chk("gap_valid", emergency_valid, 0);
    for (int i = 0; i < 3; i++) step('0, 1'b0, 1'b1);
    step('0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step('0, 1'b0, 1'b1);

    // Re-detection of the served channel
    for (int i = 0; i < 3; i++) step(4'b0001, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b0001, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) step('0, 1'b0, 1'b1);
    step('0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step('0, 1'b0, 1'b1);
    step('0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) step('0, 1'b0, 1'b1);

    // Long service without ack (timeout when enabled)
    for (int i = 0; i < 3; i++) step(4'b0100, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) step('0, 1'b0, 1'b1);
    step('0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) step('0, 1'b0, 1'b1);

    // Reset during service with requests pending
    for (int i = 0; i < 3; i++) step(4'b0111, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0);
    chk("rst_mid_valid", emergency_valid, 0);
    chk("rst_mid_pulse", detect_pulse, 0);
    for (int i = 0; i < 5; i++) step('0, 1'b1, 1'b1);
    chk("rst_mid_idle", emergency_valid, 0);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NUM_CH; i++) rs[i] = ($urandom_range(0, 9) < 7);
      ra = ($urandom_range(0, 3) == 0);
      rr = ($urandom_range(0, 199) != 0);
      step(rs, ra, rr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/emergency_detector.md
EMERGENCY_DETECTOR -- requirements
Module: emergency_detector

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent siren inputs (one per approach lane), legal range 2..16.
REQ-002 SHALL have parameter THRESH, default 3, consecutive high samples required for detection, legal range 1..255.
REQ-003 SHALL have parameter HOLD_CYCLES, default 16, service timeout in cycles (used only with REQ-026), legal range 1..65535.
REQ-004 SHALL derive localparam CH_W = max(1, clog2(NUM_CH)).
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-007 SHALL have port sound_in  input  NUM_CH  per-channel siren sample, bit i = channel i.
REQ-008 SHALL have port ack  input  1  controller acknowledges the channel currently served.
REQ-009 SHALL have port detect_pulse  output  NUM_CH  one-cycle detection strobe per channel.
REQ-010 SHALL have port emergency_valid  output  1  a channel is being served.
REQ-011 SHALL have port emergency_ch  output  CH_W  index of the served channel, meaningful only while emergency_valid=1.

Function
REQ-012 Per channel, SHALL keep a saturating run counter: +1 on each cycle sound_in[i]=1, cleared to 0 on any cycle sound_in[i]=0, saturating at THRESH.
REQ-013 On the edge where the counter goes from THRESH-1 to THRESH, SHALL set pending[i] and assert detect_pulse[i] for exactly one cycle; sound_in high from cycle 0 through THRESH-1 gives detect_pulse in cycle THRESH.
REQ-014 While the counter is saturated, SHALL NOT re-trigger; a new detection requires sound_in[i]=0 for at least one cycle, then THRESH fresh highs.
REQ-015 Arbiter SHALL be an FSM with states IDLE and SERVE.
REQ-016 IDLE: if any pending bit is set, SHALL move to SERVE, load emergency_ch with the lowest set index (fixed priority, channel 0 highest), and clear that pending bit; otherwise stay IDLE.
REQ-017 The latency from the detect_pulse cycle to emergency_valid=1 SHALL be exactly one cycle when the arbiter is IDLE.
REQ-018 SERVE: emergency_valid=1 and emergency_ch SHALL stay stable; ack=1 SHALL return the FSM to IDLE, deasserting emergency_valid on the next cycle.
REQ-019 ack while IDLE SHALL be ignored.
REQ-020 After leaving SERVE, emergency_valid SHALL be low for at least one cycle before the next channel is served, even when pending bits remain.
REQ-021 Detections arriving during SERVE, including a new detection on the served channel, SHALL set pending and be served later; they SHALL NOT be lost.
REQ-022 If pending[i] is being cleared by the arbiter and set by a new detection on the same edge, set SHALL win.
REQ-023 Simultaneous detections on several channels SHALL all set pending; they SHALL then be served one at a time in ascending index order.

Reset
REQ-024 With reset=0 on a rising edge, SHALL clear all run counters, pending bits and the hold timer, set FSM=IDLE, detect_pulse=0, emergency_valid=0 and emergency_ch=0; reset mid-SERVE SHALL discard the service and all pending requests.
REQ-025 Reset SHALL have no asynchronous effect; outputs change only on clk edges.

Configuration
REQ-026 Macro EMERG_TIMEOUT_EN defined: in SERVE, a hold timer SHALL count cycles from entry; if HOLD_CYCLES cycles elapse without ack, the FSM SHALL return to IDLE as if acked. The timer SHALL reload on each entry to SERVE. If ack and timeout occur together, ack SHALL win; the effect is the same.
REQ-027 Macro EMERG_TIMEOUT_EN undefined: no timer logic SHALL be present; SERVE SHALL be left only by ack or reset.

Verification (defaults NUM_CH=4, THRESH=3, HOLD_CYCLES=16)
REQ-028 sound_in[2] high for cycles 0-2 -> detect_pulse[2] high in cycle 3 only, emergency_valid=1 and emergency_ch=2 from cycle 4.
REQ-029 sound_in[1] pattern 1,1,0,1,1,1 -> no pulse after the first pair; single detect_pulse[1] after the final triple; sound_in held high 20 further cycles -> no second pulse.
REQ-030 Channels 3 and 1 both detected in the same cycle -> serve ch1; ack -> valid low for 1 cycle -> serve ch3; ack -> IDLE.
REQ-031 Serving ch0 while ch0 is re-detected -> after ack and a 1-cycle gap, ch0 is served again.
REQ-032 EMERG_TIMEOUT_EN defined, serve ch2 with no ack -> valid drops after 16 SERVE cycles; undefined -> valid held 100 cycles until ack.
REQ-033 reset=0 for one edge during SERVE with two pending -> next cycle valid=0, pulses=0, no channel served until new detections.
